seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the calculator's multi-digit 7-segment display.
- Holds a packed BCD display word and presents one digit at a time to a single shared BCD-to-segment decoder.
- Drives the active-low digit enables in step with that digit.
- Provides leading-zero blanking, anti-ghosting guard time, and tear-free value updates applied only at frame boundaries.

---
 rtl/seg_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display.
// Walks the digit slots of a packed BCD word and feeds one digit at a time to
// a shared BCD-to-segment decoder. It drives active-low digit enables with a
// blanking guard at the start of every slot. It blanks leading zeros on request.
// New values are swapped in only at frame boundaries, so a frame never shows
// a mix of old and new digits.
module seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned GUARD       = 500
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value_bcd,
    input  logic                      lz_en,
    output logic [3:0]                bcd_out,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      load_ack,
    output logic                      frame_done
);

    localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0] GUARD_END = DIV_W'(GUARD);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Scan position
    logic [DIV_W-1:0]          r_div_cnt;
    logic [IDX_W-1:0]          r_idx;

    // Displayed word and the staged word waiting for a frame boundary
    logic [4*NUM_DIGITS-1:0]   r_active;
    logic [4*NUM_DIGITS-1:0]   r_shadow;
    logic                      r_pending;

    // Registered outputs
    logic [3:0]                r_bcd_out;
    logic [NUM_DIGITS-1:0]     r_an;
    logic                      r_load_ack;
    logic                      r_frame_done;

    // Combinational helpers
    logic                      w_slot_end;
    logic                      w_boundary;
    logic                      w_in_guard;
    logic [NUM_DIGITS-1:0]     w_blank;
    logic [3:0]                w_digit;
    logic                      w_digit_blank;
    logic [3:0]                w_bcd_next;
    logic [NUM_DIGITS-1:0]     w_an_next;

    assign w_slot_end = (r_div_cnt == DIV_LAST);
    assign w_boundary = w_slot_end && (r_idx == IDX_LAST);
    assign w_in_guard = (r_div_cnt < GUARD_END);

    // Leading-zero mask: walk from the most significant digit down while every digit seen so far is zero
    always_comb begin
        logic        zero_run;
        int unsigned k;
        zero_run = 1'b1;
        k        = 0;
        w_blank  = '0;
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            k        = NUM_DIGITS - 1 - j;
            zero_run = zero_run & (r_active[4*k +: 4] == 4'h0);
            w_blank[k] = lz_en & zero_run & (k != 0);
        end
    end

    // Select the digit and its blank flag for the current slot
    always_comb begin
        w_digit       = 4'h0;
        w_digit_blank = 1'b0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_digit       = r_active[4*k +: 4];
                w_digit_blank = w_blank[k];
            end
        end
    end

    // Next-cycle decoder code and digit enables for the current scan position
    always_comb begin
        w_bcd_next = w_digit_blank ? BLANK_CODE : w_digit;
        w_an_next  = '1;
        if (!w_in_guard) begin
            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                if (r_idx == IDX_W'(k)) begin
                    w_an_next[k] = 1'b0;
                end
            end
        end
    end

    // Slot timer and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_idx     <= '0;
        end else if (w_slot_end) begin
            r_div_cnt <= '0;
            r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Load handshake: stage requests, commit at the frame boundary, acknowledge once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active   <= '0;
            r_shadow   <= '0;
            r_pending  <= 1'b0;
            r_load_ack <= 1'b0;
        end else begin
            r_load_ack <= 1'b0;
            if (w_boundary && load) begin
                // A request that lands on the boundary itself goes straight to
                // the display, superseding anything staged earlier.
                r_active   <= value_bcd;
                r_pending  <= 1'b0;
                r_load_ack <= 1'b1;
            end else if (w_boundary && r_pending) begin
                r_active   <= r_shadow;
                r_pending  <= 1'b0;
                r_load_ack <= 1'b1;
            end else if (load) begin
                r_shadow  <= value_bcd;
                r_pending <= 1'b1;
            end
        end
    end

    // Registered display outputs, one cycle behind the scan position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcd_out    <= BLANK_CODE;
            r_an         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_bcd_out    <= w_bcd_next;
            r_an         <= w_an_next;
            r_frame_done <= w_boundary;
        end
    end

    assign bcd_out    = r_bcd_out;
    assign an         = r_an;
    assign load_ack   = r_load_ack;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: 4 digits, 8-cycle slots, 2-cycle guard.
// Table-driven display vectors plus directed sequences for the multi-cycle cases.
module tb_seg_scan_ctrl;

    localparam int unsigned ND = 4;
    localparam int unsigned RD = 8;
    localparam int unsigned GD = 2;
    localparam int unsigned FRAME = ND * RD;

    logic              clk;
    logic              rst_n;
    logic              load;
    logic [4*ND-1:0]   value_bcd;
    logic              lz_en;
    logic [3:0]        bcd_out;
    logic [ND-1:0]     an;
    logic              load_ack;
    logic              frame_done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] value;
        logic        lz;
        logic [15:0] exp;   // expected code per slot, slot 0 in [3:0]
    } vec_t;

    vec_t vecs[8];

    seg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .GUARD       (GD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value_bcd  (value_bcd),
        .lz_en      (lz_en),
        .bcd_out    (bcd_out),
        .an         (an),
        .load_ack   (load_ack),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // At most one digit enable may be low at any time
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            checks++;
            if ($countones(~an) > 1) begin
                failures++;
                $display("FAIL an_onehot: got %b expected at most one low at %0t", an, $time);
            end
        end
    end

    // Wait (bounded) for the next frame_done; report cycles waited and load_ack seen with it
    task automatic wait_frame(output int cnt, output logic ack);
        cnt = 0;
        ack = 1'b0;
        do begin
            @(negedge clk);
            cnt++;
        end while (frame_done !== 1'b1 && cnt < 3*FRAME);
        if (frame_done !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout: got no frame_done expected one within %0d cycles", 3*FRAME);
        end
        ack = load_ack;
    endtask

    // Check cycles 1..31 after a frame start (frame_done or reset release)
    task automatic check_frame(input logic [15:0] exp);
        int unsigned c, k, d;
        logic [3:0]  e_an;
        logic [3:0]  e_bcd;
        for (int j = 1; j < int'(FRAME); j++) begin
            @(negedge clk);
            c     = j - 1;
            k     = c / RD;
            d     = c % RD;
            e_an  = (d < GD) ? 4'hF : ~(4'b0001 << k);
            e_bcd = exp[4*k +: 4];
            chk("an", an, e_an);
            chk("bcd_out", bcd_out, e_bcd);
            chk("load_ack_quiet", load_ack, 0);
            chk("frame_done_quiet", frame_done, 0);
        end
    endtask

    initial begin
        int   cnt;
        logic ack;

        vecs[0] = '{16'h0305, 1'b1, 16'hF305};
        vecs[1] = '{16'h00A0, 1'b1, 16'hFFA0};
        vecs[2] = '{16'h00A0, 1'b0, 16'h00A0};
        vecs[3] = '{16'h0000, 1'b1, 16'hFFF0};
        vecs[4] = '{16'h1000, 1'b1, 16'h1000};
        vecs[5] = '{16'h0000, 1'b0, 16'h0000};
        vecs[6] = '{16'hF00B, 1'b1, 16'hF00B};
        vecs[7] = '{16'h0C00, 1'b1, 16'hFC00};

        rst_n     = 1'b0;
        load      = 1'b0;
        value_bcd = '0;
        lz_en     = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_an", an, 4'hF);
        chk("rst_bcd", bcd_out, 4'hF);
        chk("rst_ack", load_ack, 0);
        chk("rst_fd", frame_done, 0);

        // First frame after release: zero shown as a single 0, frame_done on cycle 32
        rst_n = 1'b1;
        check_frame(16'hFFF0);
        wait_frame(cnt, ack);
        chk("first_fd_cycle", cnt, 1);
        chk("first_fd_noack", ack, 0);

        // Table: load once per frame, check the next frame slot by slot
        foreach (vecs[i]) begin
            wait_frame(cnt, ack);
            chk("idle_noack", ack, 0);
            lz_en     = vecs[i].lz;
            value_bcd = vecs[i].value;
            load      = 1'b1;
            @(negedge clk);
            load      = 1'b0;
            wait_frame(cnt, ack);
            chk("load_fd_cycle", cnt, FRAME - 1);
            chk("load_ack_with_fd", ack, 1);
            check_frame(vecs[i].exp);
        end

        // Three loads within one frame: only the last is shown, one ack
        wait_frame(cnt, ack);
        chk("multi_pre_noack", ack, 0);
        lz_en     = 1'b1;
        value_bcd = 16'h1111;
        load      = 1'b1;
        for (int j = 1; j < int'(FRAME); j++) begin
            @(negedge clk);
            if (j == 1) value_bcd = 16'h2222;
            if (j == 2) value_bcd = 16'h9876;
            if (j == 3) load = 1'b0;
            chk("multi_ack_quiet", load_ack, 0);
            chk("multi_fd_quiet", frame_done, 0);
            chk("multi_no_1", (bcd_out == 4'h1), 0);
            chk("multi_no_2", (bcd_out == 4'h2), 0);
        end
        wait_frame(cnt, ack);
        chk("multi_fd_cycle", cnt, 1);
        chk("multi_ack", ack, 1);
        check_frame(16'h9876);

        // Load exactly on the boundary cycle bypasses staging
        wait_frame(cnt, ack);
        chk("bnd_pre_noack", ack, 0);
        for (int j = 1; j < int'(FRAME); j++) begin
            @(negedge clk);
            if (j == int'(FRAME) - 1) begin
                value_bcd = 16'h4321;
                load      = 1'b1;
            end
        end
        @(negedge clk);
        load = 1'b0;
        chk("bnd_fd", frame_done, 1);
        chk("bnd_ack", load_ack, 1);
        check_frame(16'h4321);

        // Reset mid-slot 2 with a load pending
        wait_frame(cnt, ack);
        chk("rst6_pre_noack", ack, 0);
        value_bcd = 16'h5555;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
        repeat (19) @(negedge clk);
        chk("rst6_slot2_an", an, 4'b1011);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst6_an_async", an, 4'hF);
        chk("rst6_bcd_async", bcd_out, 4'hF);
        chk("rst6_ack_async", load_ack, 0);
        chk("rst6_fd_async", frame_done, 0);
        @(negedge clk);
        chk("rst6_an_hold", an, 4'hF);
        chk("rst6_bcd_hold", bcd_out, 4'hF);
        rst_n = 1'b1;
        check_frame(16'hFFF0);
        wait_frame(cnt, ack);
        chk("rst6_fd_cycle", cnt, 1);
        chk("rst6_noack", ack, 0);
        check_frame(16'hFFF0);
        wait_frame(cnt, ack);
        chk("rst6_noack2", ack, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit
    initial begin
        #400000;
        $display("FAIL watchdog: got no completion expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
